// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch unit: one request in flight, one-entry decode buffer, redirect-with-drain.
// Optional FETCH_MISALIGN_CHECK_EN: a misaligned redirect traps into a sticky FAULT state.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  output logic        fetch_fault
);

`ifdef FETCH_MISALIGN_CHECK_EN
  typedef enum logic [2:0] {S_REQ, S_WAIT, S_HOLD, S_DRAIN, S_FAULT} state_t;
`else
  typedef enum logic [2:0] {S_REQ, S_WAIT, S_HOLD, S_DRAIN} state_t;
`endif

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] redir_pc;
  logic        redir_take;
  logic        redir_bad;
  logic        rsp_cap;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign redir_pc   = redirect_pc;
  assign redir_take = redirect_valid && (state != S_FAULT);
  assign redir_bad  = redirect_pc[1:0] != 2'b00;
`else
  logic unused_redir_lsb;
  assign unused_redir_lsb = ^redirect_pc[1:0];
  assign redir_pc   = {redirect_pc[31:2], 2'b00};
  assign redir_take = redirect_valid;
  assign redir_bad  = 1'b0;
`endif

  // A redirect in WAIT kills the response even if it lands the same cycle.
  assign rsp_cap = (state == S_WAIT) && imem_rsp_valid && !redir_take;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_REQ;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    case (state)
      S_REQ:   if (imem_req_ready) state_nxt = S_WAIT;
      S_WAIT:  if (imem_rsp_valid) state_nxt = S_HOLD;
      S_HOLD:  if (inst_ready) begin
                 state_nxt = S_REQ;
                 pc_nxt    = pc + 32'd4;
               end
      S_DRAIN: if (imem_rsp_valid) state_nxt = S_REQ;
      default: state_nxt = state;
    endcase
    // Redirect overrides everything; state choice depends on whether a request is still in flight.
    if (redir_take) begin
      pc_nxt = redir_pc;
      case (state)
        S_REQ:   state_nxt = imem_req_ready ? S_DRAIN : S_REQ;
        S_WAIT:  state_nxt = imem_rsp_valid ? S_REQ : S_DRAIN;
        S_HOLD:  state_nxt = S_REQ;
        S_DRAIN: state_nxt = imem_rsp_valid ? S_REQ : S_DRAIN;
        default: state_nxt = state;
      endcase
`ifdef FETCH_MISALIGN_CHECK_EN
      if (redir_bad) state_nxt = S_FAULT;
`endif
    end
  end

  always_comb begin
    imem_req_valid = 1'b0;
    inst_valid     = 1'b0;
    fetch_fault    = 1'b0;
    imem_req_addr  = pc;
    // Gate on rst_n so no request is presented while reset is held.
    if (state == S_REQ && rst_n) imem_req_valid = 1'b1;
    if (state == S_HOLD)         inst_valid     = 1'b1;
`ifdef FETCH_MISALIGN_CHECK_EN
    if (state == S_FAULT)        fetch_fault    = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= RESET_PC;
      inst_data <= 32'h0;
      inst_pc   <= 32'h0;
    end else begin
      pc <= pc_nxt;
      if (rsp_cap) begin
        inst_data <= imem_rsp_data;
        inst_pc   <= pc;
      end
    end
  end

  logic unused_bad;
  assign unused_bad = redir_bad;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: hand-sequenced memory/decode handshakes with hand-computed expectations.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        fetch_fault;

  int n_assert = 0;
  int n_fail   = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc), .inst_ready(inst_ready),
    .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change right after the falling edge, outputs are checked there too.
  task automatic step();
    @(negedge clk);
  endtask

  // From a REQ-state negedge: accept addr, return data one cycle later, stop in HOLD.
  task automatic to_hold(input logic [31:0] addr, input logic [31:0] data);
    chk("req_valid", imem_req_valid, 1);
    chk("req_addr", imem_req_addr, addr);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    chk("wait_req_valid", imem_req_valid, 0);
    chk("wait_inst_valid", inst_valid, 0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    step();
    imem_rsp_valid = 1'b0;
    chk("hold_inst_valid", inst_valid, 1);
    chk("hold_inst_pc", inst_pc, addr);
    chk("hold_inst_data", inst_data, data);
  endtask

  // Full fetch with optional decode stall; returns at the next REQ-state negedge.
  task automatic fetch_one(input logic [31:0] addr, input logic [31:0] data, input int stall);
    to_hold(addr, data);
    for (int i = 0; i < stall; i++) begin
      step();
      chk("stall_inst_valid", inst_valid, 1);
      chk("stall_inst_pc", inst_pc, addr);
      chk("stall_inst_data", inst_data, data);
      chk("stall_no_req", imem_req_valid, 0);
    end
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    chk("consumed_inst_valid", inst_valid, 0);
  endtask

  initial begin
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0; inst_ready = 1'b0;
    step(); step();
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_inst_data", inst_data, 0);
    chk("rst_inst_pc", inst_pc, 0);
    chk("rst_fault", fetch_fault, 0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_req_valid", imem_req_valid, 1);
    chk("post_rst_req_addr", imem_req_addr, 32'h0);
    step();

    // Sequential stream 0x0, 0x4, 0x8 at 3 cycles per instruction.
    fetch_one(32'h0, 32'hC0DE_0000, 0);
    fetch_one(32'h4, 32'hC0DE_0004, 0);
    fetch_one(32'h8, 32'hC0DE_0008, 0);
    // Decode stall of 5 cycles at 0xC.
    fetch_one(32'hC, 32'hC0DE_000C, 5);

    // Redirect in WAIT, late response dropped.
    chk("r37_req_addr", imem_req_addr, 32'h10);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    step();
    redirect_valid = 1'b0;
    chk("drain_req_valid", imem_req_valid, 0);
    chk("drain_inst_valid", inst_valid, 0);
    step();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
    step();
    imem_rsp_valid = 1'b0;
    chk("drop_inst_valid", inst_valid, 0);
    chk("redir_req_valid", imem_req_valid, 1);
    chk("redir_req_addr", imem_req_addr, 32'h100);
    fetch_one(32'h100, 32'hC0DE_0100, 0);

    // Redirect in HOLD with inst_ready=1 wins over pc+4.
    to_hold(32'h104, 32'hC0DE_0104);
    inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200;
    step();
    inst_ready = 1'b0; redirect_valid = 1'b0;
    chk("r38_inst_valid", inst_valid, 0);
    chk("r38_req_valid", imem_req_valid, 1);
    chk("r38_req_addr", imem_req_addr, 32'h200);

    // Redirect in REQ while stalled; address then held stable without ready.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    chk("r23_req_addr", imem_req_addr, 32'hFFFF_FFFC);
    step();
    chk("stable_req_valid", imem_req_valid, 1);
    chk("stable_req_addr", imem_req_addr, 32'hFFFF_FFFC);
    fetch_one(32'hFFFF_FFFC, 32'hC0DE_FFFC, 0);
    chk("wrap_req_addr", imem_req_addr, 32'h0);

    // Redirect in REQ with ready=1: old request drained.
    imem_req_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h300;
    step();
    imem_req_ready = 1'b0; redirect_valid = 1'b0;
    chk("r24_req_valid", imem_req_valid, 0);
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBAD0_0000;
    step();
    imem_rsp_valid = 1'b0;
    chk("r24_inst_valid", inst_valid, 0);
    chk("r24_req_addr", imem_req_addr, 32'h300);

    // Redirect in WAIT coincident with response: response discarded, straight to REQ.
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBAD0_0300;
    redirect_valid = 1'b1; redirect_pc = 32'h400;
    step();
    imem_rsp_valid = 1'b0; redirect_valid = 1'b0;
    chk("r25_inst_valid", inst_valid, 0);
    chk("r25_req_valid", imem_req_valid, 1);
    chk("r25_req_addr", imem_req_addr, 32'h400);

    // Misaligned redirect to 0x102.
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    step();
    redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("r40_fault", fetch_fault, 1);
    chk("r40_req_valid", imem_req_valid, 0);
    redirect_valid = 1'b1; redirect_pc = 32'h500;
    step();
    redirect_valid = 1'b0;
    step();
    chk("r40_fault_sticky", fetch_fault, 1);
    chk("r40_req_after", imem_req_valid, 0);
    chk("r40_inst_after", inst_valid, 0);
`else
    chk("r40_fault", fetch_fault, 0);
    chk("r40_req_valid", imem_req_valid, 1);
    chk("r40_req_addr", imem_req_addr, 32'h100);
    fetch_one(32'h100, 32'hC0DE_0100, 0);

    // Reset while a request is outstanding.
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
`endif
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_req_valid", imem_req_valid, 0);
    chk("midrst_inst_valid", inst_valid, 0);
    chk("midrst_inst_pc", inst_pc, 0);
    chk("midrst_fault", fetch_fault, 0);
    step();
    rst_n = 1'b1;
    #1;
    chk("rerst_req_valid", imem_req_valid, 1);
    chk("rerst_req_addr", imem_req_addr, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
